// File: rtl/tryx_periph_arbiter.sv
// tryx_periph_arbiter
//   Shares one downstream peripheral/AXI-bridge port between NB_CORES cores
//   using round-robin arbitration. An in-order ID FIFO remembers which core
//   issued each outstanding request, so every response is routed back to that
//   core. The response's slave-error bit comes back as a one-cycle per-core
//   pulse for the tryx control register.
//
// Ports
//   clk_i, rst_ni              clock, async active-low reset
//   req_i/add_i/wen_i/         per-core request, address, write enable (0 = write),
//   wdata_i/be_i/user_i        write data, byte enables, AXI user tag
//   gnt_o                      per-core grant
//   r_valid_o                  per-core response valid
//   r_rdata_o/r_opc_o          response data/opcode, broadcast to all cores
//   slverr_valid_o/slverr_o    per-core slave-error pulse and bit
//   req_o..user_o, gnt_i       downstream request channel
//   r_valid_i/r_rdata_i/       downstream response channel
//   r_opc_i/slverr_i
//   outst_o                    outstanding request count
//   err_o                      sticky: response received with nothing outstanding
//
// Lock FSM
//   state     | meaning
//   ST_OPEN   | free arbitration from rr_q
//   ST_LOCKED | downstream stalled; selection pinned to lsel_q until handshake
module tryx_periph_arbiter #(
  parameter int unsigned NB_CORES       = 4,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned MAX_OUTST      = 4
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [NB_CORES-1:0]                      req_i,
  input  logic [NB_CORES-1:0][31:0]                add_i,
  input  logic [NB_CORES-1:0]                      wen_i,
  input  logic [NB_CORES-1:0][31:0]                wdata_i,
  input  logic [NB_CORES-1:0][3:0]                 be_i,
  input  logic [NB_CORES-1:0][AXI_USER_WIDTH-1:0]  user_i,
  output logic [NB_CORES-1:0]                      gnt_o,
  output logic [NB_CORES-1:0]                      r_valid_o,
  output logic [31:0]                              r_rdata_o,
  output logic                                     r_opc_o,
  output logic [NB_CORES-1:0]                      slverr_valid_o,
  output logic [NB_CORES-1:0]                      slverr_o,
  output logic                                     req_o,
  output logic [31:0]                              add_o,
  output logic                                     wen_o,
  output logic [31:0]                              wdata_o,
  output logic [3:0]                               be_o,
  output logic [AXI_USER_WIDTH-1:0]                user_o,
  input  logic                                     gnt_i,
  input  logic                                     r_valid_i,
  input  logic [31:0]                              r_rdata_i,
  input  logic                                     r_opc_i,
  input  logic                                     slverr_i,
  output logic [$clog2(MAX_OUTST+1)-1:0]           outst_o,
  output logic                                     err_o
);

  localparam int unsigned IDX_W = $clog2(NB_CORES);
  localparam int unsigned PTR_W = $clog2(MAX_OUTST);
  localparam int unsigned CNT_W = $clog2(MAX_OUTST+1);

  typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_e;

  lock_state_e      lock_q, lock_d;
  logic [IDX_W-1:0] lsel_q, lsel_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] rr_sel, sel, head;
  logic             rr_found;
  logic             sel_req, full, hs, pop;

  logic [IDX_W-1:0] id_q [MAX_OUTST];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             err_q;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    return IDX_W'(s % NB_CORES);
  endfunction

  // First requester at or after rr_q, with wrap-around.
  always_comb begin
    rr_sel   = rr_q;
    rr_found = 1'b0;
    for (int unsigned i = 0; i < NB_CORES; i++) begin
      if (!rr_found && req_i[wrap_idx(rr_q, i)]) begin
        rr_found = 1'b1;
        rr_sel   = wrap_idx(rr_q, i);
      end
    end
  end

  assign sel = (lock_q == ST_LOCKED) ? lsel_q : rr_sel;
  // Unlocked, req_i[rr_sel] equals |req_i. Locked, only the pinned core counts,
  // so a core that drops its request while locked is never granted.
  assign sel_req = req_i[sel];
  assign full    = (count_q == CNT_W'(MAX_OUTST));
  assign req_o   = sel_req & ~full;
  assign hs      = req_o & gnt_i;

  always_comb begin
    gnt_o      = '0;
    gnt_o[sel] = hs;
  end

  always_comb begin
    add_o   = '0;
    wen_o   = 1'b1;
    wdata_o = '0;
    be_o    = '0;
    user_o  = '0;
    if (req_o) begin
      add_o   = add_i[sel];
      wen_o   = wen_i[sel];
      wdata_o = wdata_i[sel];
      be_o    = be_i[sel];
      user_o  = user_i[sel];
    end
  end

  always_comb begin
    lock_d = lock_q;
    lsel_d = lsel_q;
    unique case (lock_q)
      ST_OPEN: begin
        if (req_o && !gnt_i) begin
          lock_d = ST_LOCKED;
          lsel_d = sel;
        end
      end
      ST_LOCKED: begin
        if (hs || !req_i[lsel_q]) lock_d = ST_OPEN;
      end
      default: lock_d = ST_OPEN;
    endcase
  end

  always_comb begin
    rr_d = rr_q;
    if (hs) rr_d = (sel == IDX_W'(NB_CORES-1)) ? '0 : sel + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= ST_OPEN;
      lsel_q <= '0;
      rr_q   <= '0;
    end else begin
      lock_q <= lock_d;
      lsel_q <= lsel_d;
      rr_q   <= rr_d;
    end
  end

  assign pop  = r_valid_i & (count_q != '0);
  assign head = id_q[rptr_q];

  // ID storage needs no reset: entries are only read while count_q covers them.
  always_ff @(posedge clk_i) begin
    if (hs) id_q[wptr_q] <= sel;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (hs)  wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      unique case ({hs, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (r_valid_i && count_q == '0) err_q <= 1'b1;
    end
  end

  always_comb begin
    r_valid_o      = '0;
    slverr_valid_o = '0;
    slverr_o       = '0;
    if (count_q != '0) begin
      r_valid_o[head]      = r_valid_i;
      slverr_valid_o[head] = r_valid_i;
      slverr_o[head]       = slverr_i;
    end
  end

  assign r_rdata_o = r_rdata_i;
  assign r_opc_o   = r_opc_i;
  assign outst_o   = count_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_tryx_periph_arbiter.sv
// Self-checking bench for tryx_periph_arbiter. A queue-based reference model
// (round-robin pointer, lock, in-order queue of issuing cores, sticky error)
// predicts every output each cycle; directed scenarios are followed by a
// randomized run.
module tb_tryx_periph_arbiter;
  localparam int N  = 4;
  localparam int UW = 6;
  localparam int MO = 4;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [N-1:0]          req_i;
  logic [N-1:0][31:0]    add_i;
  logic [N-1:0]          wen_i;
  logic [N-1:0][31:0]    wdata_i;
  logic [N-1:0][3:0]     be_i;
  logic [N-1:0][UW-1:0]  user_i;
  logic [N-1:0]          gnt_o, r_valid_o, slverr_valid_o, slverr_o;
  logic [31:0]           r_rdata_o;
  logic                  r_opc_o;
  logic                  req_o, wen_o;
  logic [31:0]           add_o, wdata_o;
  logic [3:0]            be_o;
  logic [UW-1:0]         user_o;
  logic                  gnt_i, r_valid_i, r_opc_i, slverr_i;
  logic [31:0]           r_rdata_i;
  logic [2:0]            outst_o;
  logic                  err_o;

  always #5 clk_i = ~clk_i;

  tryx_periph_arbiter #(.NB_CORES(N), .AXI_USER_WIDTH(UW), .MAX_OUTST(MO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .wdata_i(wdata_i),
    .be_i(be_i), .user_i(user_i), .gnt_o(gnt_o),
    .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o),
    .slverr_valid_o(slverr_valid_o), .slverr_o(slverr_o),
    .req_o(req_o), .add_o(add_o), .wen_o(wen_o), .wdata_o(wdata_o),
    .be_o(be_o), .user_o(user_o), .gnt_i(gnt_i),
    .r_valid_i(r_valid_i), .r_rdata_i(r_rdata_i), .r_opc_i(r_opc_i),
    .slverr_i(slverr_i), .outst_o(outst_o), .err_o(err_o)
  );

  int checks   = 0;
  int failures = 0;

  // reference model state and its pending next values
  int m_rr, m_lidx, m_q[$];
  bit m_lk, m_err;
  int n_rr, n_lidx, n_pushid;
  bit n_lk, n_err, n_push, n_pop;
  bit hold_fields = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_lk = 0; m_lidx = 0; m_err = 0;
    m_q.delete();
  endtask

  task automatic check_now();
    int sel, head;
    bit found, ereq, hs, pop;
    logic [N-1:0] egnt, erv, eslv;
    sel = m_rr;
    found = 0;
    if (m_lk) sel = m_lidx;
    else
      for (int i = 0; i < N; i++)
        if (!found && req_i[(m_rr + i) % N]) begin
          found = 1;
          sel = (m_rr + i) % N;
        end
    ereq = (m_lk ? req_i[m_lidx] : (|req_i)) && (m_q.size() < MO);
    hs   = ereq && gnt_i;
    egnt = '0;
    if (hs) egnt[sel] = 1'b1;
    erv  = '0;
    eslv = '0;
    pop  = r_valid_i && (m_q.size() > 0);
    head = (m_q.size() > 0) ? m_q[0] : 0;
    if (m_q.size() > 0) begin
      erv[head]  = r_valid_i;
      eslv[head] = slverr_i;
    end
    chk("req_o",   64'(req_o),   64'(ereq));
    chk("gnt_o",   64'(gnt_o),   64'(egnt));
    chk("add_o",   64'(add_o),   ereq ? 64'(add_i[sel])   : 64'(0));
    chk("wen_o",   64'(wen_o),   ereq ? 64'(wen_i[sel])   : 64'(1));
    chk("wdata_o", 64'(wdata_o), ereq ? 64'(wdata_i[sel]) : 64'(0));
    chk("be_o",    64'(be_o),    ereq ? 64'(be_i[sel])    : 64'(0));
    chk("user_o",  64'(user_o),  ereq ? 64'(user_i[sel])  : 64'(0));
    chk("r_valid_o",      64'(r_valid_o),      64'(erv));
    chk("slverr_valid_o", 64'(slverr_valid_o), 64'(erv));
    chk("slverr_o",       64'(slverr_o),       64'(eslv));
    chk("r_rdata_o", 64'(r_rdata_o), 64'(r_rdata_i));
    chk("r_opc_o",   64'(r_opc_o),   64'(r_opc_i));
    chk("outst_o",   64'(outst_o),   64'(m_q.size()));
    chk("err_o",     64'(err_o),     64'(m_err));
    n_pop    = pop;
    n_push   = hs;
    n_pushid = sel;
    n_rr     = hs ? (sel + 1) % N : m_rr;
    n_lk     = m_lk;
    n_lidx   = m_lidx;
    if (hs) n_lk = 0;
    else if (ereq && !gnt_i) begin n_lk = 1; n_lidx = sel; end
    else if (m_lk && !req_i[m_lidx]) n_lk = 0;
    n_err = m_err | (r_valid_i && m_q.size() == 0);
  endtask

  task automatic apply_edge();
    if (n_pop) void'(m_q.pop_front());
    if (n_push) m_q.push_back(n_pushid);
    m_rr = n_rr; m_lk = n_lk; m_lidx = n_lidx; m_err = n_err;
  endtask

  task automatic cycle();
    #2;
    check_now();
    @(posedge clk_i);
    apply_edge();
    #1;
  endtask

  task automatic drive(input logic [N-1:0] rq, input logic g, input logic rv, input logic se);
    req_i = rq; gnt_i = g; r_valid_i = rv; slverr_i = se;
    if (!hold_fields)
      for (int k = 0; k < N; k++) begin
        add_i[k]   = $urandom;
        wdata_i[k] = $urandom;
        wen_i[k]   = 1'($urandom_range(0, 1));
        be_i[k]    = 4'($urandom);
        user_i[k]  = UW'($urandom);
      end
    r_rdata_i = $urandom;
    r_opc_i   = 1'($urandom_range(0, 1));
    cycle();
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * MO && m_q.size() > 0; i++) drive('0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
  endtask

  // async reset asserted mid-cycle; outputs checked while reset is held
  task automatic mid_reset();
    rst_ni = 1'b0;
    model_reset();
    req_i = '0; gnt_i = 0; r_valid_i = 0; slverr_i = 0;
    #1;
    check_now();
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    req_i = '0; gnt_i = 0; r_valid_i = 0; slverr_i = 0; r_opc_i = 0; r_rdata_i = '0;
    add_i = '0; wdata_i = '0; wen_i = '1; be_i = '0; user_i = '0;
    model_reset();
    @(posedge clk_i); @(posedge clk_i); #1;
    check_now();
    rst_ni = 1'b1;

    // lock under backpressure: cores 1,2 stall, core 0 joins, core 1 wins
    hold_fields = 1;
    for (int k = 0; k < N; k++) begin add_i[k] = 32'h1000_0000 + k; wdata_i[k] = $urandom; end
    drive(4'b0110, 0, 0, 0);
    drive(4'b0111, 0, 0, 0);
    drive(4'b0111, 1, 0, 0);
    hold_fields = 0;
    drive(4'b0000, 0, 1, 0);

    // round-robin with one response per cycle (first response is spurious)
    for (int i = 0; i < 8; i++) drive(4'b1111, 1, 1, 1'($urandom_range(0, 1)));
    drain();

    // full and drain
    for (int i = 0; i < MO; i++) drive(4'b1000, 1, 0, 0);
    drive(4'b1000, 1, 1, 0);
    drive(4'b1000, 1, 0, 0);
    drain();

    // out-of-core ordering
    drive(4'b0100, 1, 0, 0);
    drive(4'b0001, 1, 0, 0);
    drive(4'b0010, 1, 0, 0);
    drive(4'b0000, 0, 1, 1);
    drive(4'b0000, 0, 1, 0);
    drive(4'b0000, 0, 1, 1);

    // simultaneous push and pop at two outstanding
    drive(4'b0001, 1, 0, 0);
    drive(4'b0100, 1, 0, 0);
    drive(4'b1000, 1, 1, 1);
    drain();

    // spurious response, then reset mid-burst with three outstanding
    drive(4'b0000, 0, 1, 0);
    drive(4'b0000, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(4'b1111, 1, 0, 0);
    mid_reset();
    drive(4'b1111, 1, 0, 0);
    drain();
    drive(4'b0000, 0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      drive(N'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
